if_stage: RTL and testbench



---
 rtl/if_stage_if.sv | 21 ++
 rtl/if_stage.sv | 143 ++++++++++++++
 tb/tb_if_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// I-cache fetch port of the IF stage: request/address out, instruction/stall back.
interface if_stage_if;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;

  modport master (
    output ICACHE_ren,
    output ICACHE_addr,
    input  ICACHE_rdata,
    input  ICACHE_stall
  );

  modport slave (
    input  ICACHE_ren,
    input  ICACHE_addr,
    output ICACHE_rdata,
    output ICACHE_stall
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage with PC, IF/ID register and held-redirect FSM.
// Define IF_STAGE_PERF_EN to add saturating fetch/bubble performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  if_stage_if.master        icache,
  input  logic              hazard_stall,
  input  logic              hazard_flush,
  input  logic              branch_flag,
  input  logic [31:0]       branch_target,
  output logic [31:0]       IF_ID_pc,
  output logic [31:0]       IF_ID_inst,
  output logic              IF_ID_valid,
  output logic [6:0]        IF_ID_op,
  output logic [4:0]        IF_ID_rs1,
  output logic [4:0]        IF_ID_rs2,
`ifdef IF_STAGE_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt,
`endif
  output logic [31:0]       pc_plus4
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        load_valid;
  logic        load_bubble;

  // A redirect seen during an I-cache stall is parked in pend_pc and applied
  // on release; a branch live in the release cycle is newer and wins.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    id_pc_d     = id_pc_q;
    valid_d     = valid_q;
    pend_pc_d   = pend_pc_q;
    load_valid  = 1'b0;
    load_bubble = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (icache.ICACHE_stall) begin
          if (branch_flag) begin
            pend_pc_d = branch_target;
            state_d   = PEND;
          end
        end else if (hazard_stall) begin
          pc_d = pc_q;
        end else if (branch_flag) begin
          pc_d        = branch_target;
          load_bubble = 1'b1;
        end else if (hazard_flush) begin
          pc_d        = pc_q + 32'd4;
          load_bubble = 1'b1;
        end else begin
          inst_d     = icache.ICACHE_rdata;
          id_pc_d    = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + 32'd4;
          load_valid = 1'b1;
        end
      end
      PEND: begin
        if (icache.ICACHE_stall) begin
          if (branch_flag) pend_pc_d = branch_target;
        end else begin
          pc_d        = branch_flag ? branch_target : pend_pc_q;
          load_bubble = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    if (load_bubble) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      id_pc_q   <= 32'd0;
      valid_q   <= 1'b0;
      pend_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      id_pc_q   <= id_pc_d;
      valid_q   <= valid_d;
      pend_pc_q <= pend_pc_d;
    end
  end

`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (load_valid && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (load_bubble && bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

  assign icache.ICACHE_ren  = !rst && (state_q != BOOT);
  assign icache.ICACHE_addr = pc_q[31:2];
  assign IF_ID_pc           = id_pc_q;
  assign IF_ID_inst         = inst_q;
  assign IF_ID_valid        = valid_q;
  assign IF_ID_op           = inst_q[6:0];
  assign IF_ID_rs1          = inst_q[19:15];
  assign IF_ID_rs2          = inst_q[24:20];
  assign pc_plus4           = id_pc_q + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: fetch, stalls, redirects, held redirects, reset in PEND.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        hazard_stall;
  logic        hazard_flush;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_valid;
  logic [6:0]  IF_ID_op;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic [31:0] pc_plus4;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int checks;
  int failures;

  if_stage_if icache ();

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .icache        (icache.master),
    .hazard_stall  (hazard_stall),
    .hazard_flush  (hazard_flush),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_inst    (IF_ID_inst),
    .IF_ID_valid   (IF_ID_valid),
    .IF_ID_op      (IF_ID_op),
    .IF_ID_rs1     (IF_ID_rs1),
    .IF_ID_rs2     (IF_ID_rs2),
`ifdef IF_STAGE_PERF_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt),
`endif
    .pc_plus4      (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then settle just after the edge.
  task automatic applyStimulus(input logic hs, input logic hf, input logic br,
                               input logic [31:0] tgt, input logic cst, input logic [31:0] rdata);
    hazard_stall        = hs;
    hazard_flush        = hf;
    branch_flag         = br;
    branch_target       = tgt;
    icache.ICACHE_stall = cst;
    icache.ICACHE_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic valid);
    checkOutput({tag, "_pc"}, IF_ID_pc, pc);
    checkOutput({tag, "_inst"}, IF_ID_inst, inst);
    checkOutput({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, valid});
  endtask

  initial begin
    checks              = 0;
    failures            = 0;
    rst                 = 1'b1;
    hazard_stall        = 1'b0;
    hazard_flush        = 1'b0;
    branch_flag         = 1'b0;
    branch_target       = 32'd0;
    icache.ICACHE_stall = 1'b0;
    icache.ICACHE_rdata = 32'd0;

    applyStimulus(0, 0, 0, 32'd0, 0, 32'd0);
    checkOutput("rst_ren", {31'd0, icache.ICACHE_ren}, 32'd0);
    checkOutput("rst_addr", {2'd0, icache.ICACHE_addr}, 32'd0);
    checkIfId("rst", 32'd0, 32'h13, 1'b0);
`ifdef IF_STAGE_PERF_EN
    checkOutput("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    checkOutput("rst_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("boot_ren", {31'd0, icache.ICACHE_ren}, 32'd0);
    applyStimulus(0, 0, 0, 32'd0, 0, 32'hDEAD_BEEF);
    checkOutput("run_ren", {31'd0, icache.ICACHE_ren}, 32'd1);
    checkOutput("boot_addr", {2'd0, icache.ICACHE_addr}, 32'd0);
    checkIfId("boot", 32'd0, 32'h13, 1'b0);

    applyStimulus(0, 0, 0, 32'd0, 0, 32'h11);
    checkIfId("f0", 32'd0, 32'h11, 1'b1);
    checkOutput("f0_addr", {2'd0, icache.ICACHE_addr}, 32'd1);
    applyStimulus(0, 0, 0, 32'd0, 0, 32'h22);
    checkIfId("f1", 32'd4, 32'h22, 1'b1);
    checkOutput("f1_addr", {2'd0, icache.ICACHE_addr}, 32'd2);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 32'd0, 0, 32'h99);
      checkIfId("hstall", 32'd4, 32'h22, 1'b1);
      checkOutput("hstall_addr", {2'd0, icache.ICACHE_addr}, 32'd2);
    end

    applyStimulus(0, 0, 0, 32'd0, 0, 32'h33);
    checkIfId("f2", 32'd8, 32'h33, 1'b1);
    checkOutput("f2_addr", {2'd0, icache.ICACHE_addr}, 32'd3);
    applyStimulus(0, 0, 0, 32'd0, 0, 32'h44);
    checkIfId("f3", 32'd12, 32'h44, 1'b1);
    checkOutput("f3_addr", {2'd0, icache.ICACHE_addr}, 32'd4);
    checkOutput("f3_pc_plus4", pc_plus4, 32'd16);

    applyStimulus(0, 0, 1, 32'h100, 0, 32'h77);
    checkIfId("br", 32'd12, 32'h13, 1'b0);
    checkOutput("br_addr", {2'd0, icache.ICACHE_addr}, 32'h40);
    applyStimulus(0, 0, 0, 32'd0, 0, 32'h0020_8033);
    checkIfId("br_tgt", 32'h100, 32'h0020_8033, 1'b1);
    checkOutput("dec_op", {25'd0, IF_ID_op}, 32'h33);
    checkOutput("dec_rs1", {27'd0, IF_ID_rs1}, 32'd1);
    checkOutput("dec_rs2", {27'd0, IF_ID_rs2}, 32'd2);
    checkOutput("br_pc_plus4", pc_plus4, 32'h104);

    applyStimulus(0, 0, 0, 32'd0, 1, 32'hBAD0_0001);
    applyStimulus(0, 0, 1, 32'h200, 1, 32'hBAD0_0002);
    applyStimulus(0, 0, 0, 32'd0, 1, 32'hBAD0_0003);
    checkIfId("istall", 32'h100, 32'h0020_8033, 1'b1);
    checkOutput("istall_addr", {2'd0, icache.ICACHE_addr}, 32'h41);
    applyStimulus(0, 0, 0, 32'd0, 0, 32'hBAD0_0004);
    checkIfId("pend_rel", 32'h100, 32'h13, 1'b0);
    checkOutput("pend_rel_addr", {2'd0, icache.ICACHE_addr}, 32'h80);

    applyStimulus(0, 0, 0, 32'd0, 0, 32'hAAAA_0013);
    checkIfId("f4", 32'h200, 32'hAAAA_0013, 1'b1);
    applyStimulus(1, 1, 0, 32'd0, 0, 32'h55);
    checkIfId("flush_stall", 32'h200, 32'hAAAA_0013, 1'b1);
    checkOutput("flush_stall_addr", {2'd0, icache.ICACHE_addr}, 32'h81);
    applyStimulus(0, 1, 0, 32'd0, 0, 32'h55);
    checkIfId("flush", 32'h200, 32'h13, 1'b0);
    checkOutput("flush_addr", {2'd0, icache.ICACHE_addr}, 32'h82);

    applyStimulus(0, 0, 1, 32'h400, 1, 32'h0);
    applyStimulus(0, 0, 1, 32'h500, 0, 32'h0);
    checkOutput("pend_live_addr", {2'd0, icache.ICACHE_addr}, 32'h140);

    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'd0, 0, 32'h66);
    checkIfId("wrap", 32'hFFFF_FFFC, 32'h66, 1'b1);
    checkOutput("wrap_addr", {2'd0, icache.ICACHE_addr}, 32'd0);
    checkOutput("wrap_pc_plus4", pc_plus4, 32'd0);

    applyStimulus(0, 0, 1, 32'h300, 1, 32'h0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 32'd0, 1, 32'h0);
    checkIfId("rst_pend", 32'd0, 32'h13, 1'b0);
`ifdef IF_STAGE_PERF_EN
    checkOutput("rst_pend_perf_fetch", perf_fetch_cnt, 32'd0);
    checkOutput("rst_pend_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
    rst = 1'b0;
    applyStimulus(0, 0, 0, 32'd0, 0, 32'h0);
    checkOutput("rst_pend_addr", {2'd0, icache.ICACHE_addr}, 32'd0);
    applyStimulus(0, 0, 0, 32'd0, 0, 32'h88);
    checkIfId("after_rst", 32'd0, 32'h88, 1'b1);
    checkOutput("after_rst_addr", {2'd0, icache.ICACHE_addr}, 32'd1);
`ifdef IF_STAGE_PERF_EN
    applyStimulus(0, 1, 0, 32'd0, 0, 32'h0);
    checkOutput("perf_fetch", perf_fetch_cnt, 32'd1);
    checkOutput("perf_bubble", perf_bubble_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
